// File: rtl/oddr_tx_serializer.sv
// oddr_tx_serializer
//   Transmit-side word serializer feeding an ODDR primitive in SAME_EDGE mode.
//   Parallel words arrive over a valid/ready handshake and leave as one
//   (rising, falling) bit pair per cycle on D1/D2. A holding register in front
//   of the shifter lets the next word follow the last pair of the current one
//   with no gap.
// Ports
//   C          clock, rising edge
//   R          synchronous reset, active high, overrides CE
//   CE         clock enable; low freezes all state
//   DIN        word to transmit (WORD_WIDTH bits)
//   DIN_VALID  DIN is valid
//   DIN_READY  block can take DIN this cycle
//   D1 / D2    registered rising / falling-edge bits to the ODDR
//   FRAME      high while D1/D2 carry pair0 of a word
//   BUSY       high while a word is being shifted out
//   UNDERRUN   one-cycle pulse when the stream ends because hold was empty
module oddr_tx_serializer #(
  parameter int   WORD_WIDTH = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic INIT_Q1    = 1'b0,
  parameter logic INIT_Q2    = 1'b0
) (
  input  logic                  C,
  input  logic                  R,
  input  logic                  CE,
  input  logic [WORD_WIDTH-1:0] DIN,
  input  logic                  DIN_VALID,
  output logic                  DIN_READY,
  output logic                  D1,
  output logic                  D2,
  output logic                  FRAME,
  output logic                  BUSY,
  output logic                  UNDERRUN
);

  localparam int W    = WORD_WIDTH;
  localparam int P    = W / 2;
  localparam int CW   = (P > 1) ? $clog2(P) : 1;
  localparam logic [CW-1:0] LAST = CW'(P - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   hold_q, hold_d;
  logic           hold_full_q, hold_full_d;
  logic [W-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           d1_q, d1_d, d2_q, d2_d;
  logic           frame_q, frame_d;
  logic           underrun_q, underrun_d;

  logic           hold_drain;
  logic           accept;

  // Pair presented first from a word (or from the remaining shifter bits).
  function automatic logic [1:0] first_pair(input logic [W-1:0] w);
    return MSB_FIRST ? {w[W-1], w[W-2]} : {w[0], w[1]};
  endfunction

  // Drop the pair just presented so the next one sits at the output end.
  function automatic logic [W-1:0] drop_pair(input logic [W-1:0] w);
    return MSB_FIRST ? (w << 2) : (w >> 2);
  endfunction

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    frame_d     = frame_q;
    underrun_d  = underrun_q;

    hold_drain = CE & hold_full_q &
                 ((state_q == S_IDLE) | ((state_q == S_SHIFT) & (cnt_q == LAST)));
    // Ready depends only on registered state, CE and R: no path from DIN_VALID.
    DIN_READY  = CE & ~R & (~hold_full_q | hold_drain);
    accept     = DIN_VALID & DIN_READY;

    if (CE) begin
      // A drain and an accept on the same edge keep hold full with the new word.
      hold_full_d = (hold_full_q & ~hold_drain) | accept;
      if (accept) hold_d = DIN;
      frame_d    = 1'b0;
      underrun_d = 1'b0;

      unique case (state_q)
        S_IDLE: begin
          d1_d = INIT_Q1;
          d2_d = INIT_Q2;
          if (hold_drain) begin
            {d1_d, d2_d} = first_pair(hold_q);
            shreg_d      = drop_pair(hold_q);
            frame_d      = 1'b1;
            cnt_d        = '0;
            state_d      = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (cnt_q != LAST) begin
            {d1_d, d2_d} = first_pair(shreg_q);
            shreg_d      = drop_pair(shreg_q);
            cnt_d        = cnt_q + CW'(1);
          end else if (hold_full_q) begin
            // Back-to-back word: pair0 directly after the previous last pair.
            {d1_d, d2_d} = first_pair(hold_q);
            shreg_d      = drop_pair(hold_q);
            frame_d      = 1'b1;
            cnt_d        = '0;
          end else begin
            d1_d       = INIT_Q1;
            d2_d       = INIT_Q2;
            underrun_d = 1'b1;
            cnt_d      = '0;
            state_d    = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      d1_q        <= INIT_Q1;
      d2_q        <= INIT_Q2;
      frame_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      frame_q     <= frame_d;
      underrun_q  <= underrun_d;
    end
  end

  assign D1       = d1_q;
  assign D2       = d2_q;
  assign FRAME    = frame_q;
  assign BUSY     = (state_q == S_SHIFT);
  assign UNDERRUN = underrun_q;

endmodule

// File: tb/tb_oddr_tx_serializer.sv
module tb_oddr_tx_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r, ce;
  logic [7:0] din8;
  logic       v8, rdy8, d1_8, d2_8, fr8, busy8, ur8;
  logic [1:0] din2;
  logic       v2, rdy2, d1_2, d2_2, fr2, busy2, ur2;

  oddr_tx_serializer #(.WORD_WIDTH(8), .MSB_FIRST(1'b1), .INIT_Q1(1'b0), .INIT_Q2(1'b0)) u_w8 (
    .C(clk), .R(r), .CE(ce), .DIN(din8), .DIN_VALID(v8), .DIN_READY(rdy8),
    .D1(d1_8), .D2(d2_8), .FRAME(fr8), .BUSY(busy8), .UNDERRUN(ur8)
  );

  oddr_tx_serializer #(.WORD_WIDTH(2), .MSB_FIRST(1'b1), .INIT_Q1(1'b0), .INIT_Q2(1'b0)) u_w2 (
    .C(clk), .R(r), .CE(ce), .DIN(din2), .DIN_VALID(v2), .DIN_READY(rdy2),
    .D1(d1_2), .D2(d2_2), .FRAME(fr2), .BUSY(busy2), .UNDERRUN(ur2)
  );

  int errors = 0;
  int checks = 0;
  int ur_cnt8 = 0;
  int ur_cnt2 = 0;
  logic       ce_seen = 1'b0;
  logic [2:0] q8[$];   // expected {D1,D2,FRAME} per presented pair
  logic [2:0] q2[$];
  logic [2:0] e8, e2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A new pair is presented only on edges where CE was high.
  always @(posedge clk) ce_seen <= ce;

  // Scoreboard monitors: pop one expected pair per new presented pair.
  always @(negedge clk) begin
    if (busy8 === 1'b1) begin
      if (ce_seen) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL w8_extra_pair: got %b%b%b expected none", d1_8, d2_8, fr8);
        end else begin
          e8 = q8.pop_front();
          chk("w8_pair", {29'd0, d1_8, d2_8, fr8}, {29'd0, e8});
        end
      end
    end else begin
      chk("w8_idle_level", {29'd0, d1_8, d2_8, fr8}, 32'd0);
    end
    if (ur8 === 1'b1 && ce_seen) ur_cnt8++;
  end

  always @(negedge clk) begin
    if (busy2 === 1'b1) begin
      if (ce_seen) begin
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL w2_extra_pair: got %b%b%b expected none", d1_2, d2_2, fr2);
        end else begin
          e2 = q2.pop_front();
          chk("w2_pair", {29'd0, d1_2, d2_2, fr2}, {29'd0, e2});
        end
      end
    end else begin
      chk("w2_idle_level", {29'd0, d1_2, d2_2, fr2}, 32'd0);
    end
    if (ur2 === 1'b1 && ce_seen) ur_cnt2++;
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Hand-computed pairs of one 8-bit word; n limits how many are expected out.
  task automatic exp8(input logic [1:0] p0, p1, p2, p3, input int n);
    logic [1:0] p [4];
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    for (int i = 0; i < n; i++) q8.push_back({p[i], (i == 0)});
  endtask

  // Present a word and hold VALID until accepted; returns 1ns after the accept edge.
  task automatic send8(input logic [7:0] w);
    bit ok;
    ok   = 1'b0;
    din8 = w;
    v8   = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (rdy8) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send8_timeout: got ready=0 expected ready=1 for %h", w);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with VALID asserted
    r = 1'b1; ce = 1'b1;
    v8 = 1'b1; din8 = 8'hFF;
    v2 = 1'b1; din2 = 2'b11;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready8", {31'd0, rdy8}, 32'd0);
      chk("rst_ready2", {31'd0, rdy2}, 32'd0);
      chk("rst_busy8", {31'd0, busy8}, 32'd0);
      chk("rst_ur8", {31'd0, ur8}, 32'd0);
      chk("rst_d8", {30'd0, d1_8, d2_8}, 32'd0);
      @(posedge clk); #1;
    end
    r = 1'b0; v8 = 1'b0; v2 = 1'b0;
    cyc(4);
    chk("rst_no_ur", ur_cnt8, 0);

    // 2: single B4 -> 10,11,01,00 then one underrun pulse
    exp8(2'b10, 2'b11, 2'b01, 2'b00, 4);
    send8(8'hB4);
    v8 = 1'b0;
    cyc(8);
    chk("t2_underruns", ur_cnt8, 1);

    // 3: A5 then 3C back to back
    exp8(2'b10, 2'b10, 2'b01, 2'b01, 4);
    exp8(2'b00, 2'b11, 2'b11, 2'b00, 4);
    send8(8'hA5);
    send8(8'h3C);
    v8 = 1'b0;
    cyc(12);
    chk("t3_underruns", ur_cnt8, 2);

    // 4: CE low for 3 cycles while beat 1 of B4 is on the pins
    exp8(2'b10, 2'b11, 2'b01, 2'b00, 4);
    send8(8'hB4);
    v8 = 1'b0;
    cyc(2);
    ce = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t4_frozen_pair", {30'd0, d1_8, d2_8}, 32'd3);
      chk("t4_ready_low", {31'd0, rdy8}, 32'd0);
      @(posedge clk); #1;
    end
    ce = 1'b1;
    cyc(8);
    chk("t4_underruns", ur_cnt8, 3);

    // 5: W=2 streaming, one word per cycle
    q2.push_back(3'b101);
    q2.push_back(3'b011);
    q2.push_back(3'b111);
    din2 = 2'b10; v2 = 1'b1;
    @(negedge clk); chk("t5_ready_a", {31'd0, rdy2}, 32'd1);
    @(posedge clk); #1;
    din2 = 2'b01;
    @(negedge clk); chk("t5_ready_b", {31'd0, rdy2}, 32'd1);
    @(posedge clk); #1;
    din2 = 2'b11;
    @(negedge clk); chk("t5_ready_c", {31'd0, rdy2}, 32'd1);
    @(posedge clk); #1;
    v2 = 1'b0;
    cyc(5);
    chk("t5_underruns", ur_cnt2, 1);

    // 6: reset during beat 2 with the next word held; held word never appears
    exp8(2'b10, 2'b11, 2'b01, 2'b00, 3);
    send8(8'hB4);
    send8(8'hA5);
    v8 = 1'b0;
    cyc(2);
    r = 1'b1;
    cyc(1);
    @(negedge clk);
    chk("t6_d_init", {30'd0, d1_8, d2_8}, 32'd0);
    chk("t6_busy", {31'd0, busy8}, 32'd0);
    chk("t6_ur", {31'd0, ur8}, 32'd0);
    chk("t6_ready", {31'd0, rdy8}, 32'd0);
    @(posedge clk); #1;
    r = 1'b0;
    cyc(10);
    chk("t6_underruns", ur_cnt8, 3);

    chk("q8_drained", q8.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
